// File: rtl/memory_2rw_wb_pipe.sv
// Dual-port Wishbone B4 pipelined RAM: byte lanes, out-of-range errors,
// port-0-priority collision stall on port 1, and cycle-abort response flush.
module memory_2rw_wb_pipe_resp #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  acc,
    input  logic                  acc_err,
    input  logic                  acc_rd,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dat
);
    localparam int STAGES = READ_LATENCY - 1;

    logic [STAGES:0]       vld_pipe, err_pipe, rd_pipe;
    logic [DATA_WIDTH-1:0] rd_q;

    // Dropping cyc zeroes every valid bit on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            rd_pipe  <= '0;
            rd_q     <= '0;
        end else begin
            vld_pipe[0] <= cyc & acc;
            err_pipe[0] <= acc_err;
            rd_pipe[0]  <= acc_rd;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= cyc & vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
            if (acc & acc_rd)
                rd_q <= rdata;
        end
    end

    assign ack = vld_pipe[STAGES] & ~err_pipe[STAGES];
    assign err = vld_pipe[STAGES] &  err_pipe[STAGES];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic unused_rd;
            assign unused_rd = ^rd_pipe;
            assign dat = rd_q;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] dat_q;
            // Output register only moves when a read ack is about to be shown.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    dat_q <= '0;
                else if (cyc & vld_pipe[STAGES-1] & rd_pipe[STAGES-1] & ~err_pipe[STAGES-1])
                    dat_q <= rd_q;
            end
            assign dat = dat_q;
        end
    endgenerate
endmodule

module memory_2rw_wb_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WMASKS   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1,
    parameter int BYTE_SHIFT   = $clog2(NUM_WMASKS)
) (
    input  logic                  port0_wb_clk_i,
    input  logic                  port0_wb_rst_i,
    input  logic                  port0_wb_cyc_i,
    input  logic                  port0_wb_stb_i,
    input  logic                  port0_wb_we_i,
    input  logic [31:0]           port0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] port0_wb_dat_i,
    input  logic [NUM_WMASKS-1:0] port0_wb_sel_i,
    output logic                  port0_wb_stall_o,
    output logic                  port0_wb_ack_o,
    output logic                  port0_wb_err_o,
    output logic [DATA_WIDTH-1:0] port0_wb_dat_o,
    input  logic                  port1_wb_cyc_i,
    input  logic                  port1_wb_stb_i,
    input  logic                  port1_wb_we_i,
    input  logic [31:0]           port1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] port1_wb_dat_i,
    input  logic [NUM_WMASKS-1:0] port1_wb_sel_i,
    output logic                  port1_wb_stall_o,
    output logic                  port1_wb_ack_o,
    output logic                  port1_wb_err_o,
    output logic [DATA_WIDTH-1:0] port1_wb_dat_o
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int AHI       = ADDR_WIDTH + BYTE_SHIFT;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [ADDR_WIDTH-1:0] idx0, idx1;
    logic                  oor0, oor1, req0, req1, acc0, acc1, collide;
    logic                  unused_adr;

    assign unused_adr = ^{port0_wb_adr_i, port1_wb_adr_i};

    assign idx0 = port0_wb_adr_i[AHI-1:BYTE_SHIFT];
    assign idx1 = port1_wb_adr_i[AHI-1:BYTE_SHIFT];
    assign oor0 = |port0_wb_adr_i[31:AHI];
    assign oor1 = |port1_wb_adr_i[31:AHI];
    assign req0 = port0_wb_cyc_i & port0_wb_stb_i;
    assign req1 = port1_wb_cyc_i & port1_wb_stb_i;

    // Port 1 backs off on a same-word conflict involving a write.
    assign collide = req0 & req1 & ~oor0 & ~oor1 & (idx0 == idx1)
                   & (port0_wb_we_i | port1_wb_we_i);

    assign port0_wb_stall_o = 1'b0;
    assign port1_wb_stall_o = collide & ~port0_wb_rst_i;

    assign acc0 = req0 & ~port0_wb_rst_i;
    assign acc1 = req1 & ~port1_wb_stall_o & ~port0_wb_rst_i;

    always_ff @(posedge port0_wb_clk_i) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (acc0 & port0_wb_we_i & ~oor0 & port0_wb_sel_i[i])
                mem[idx0][8*i +: 8] <= port0_wb_dat_i[8*i +: 8];
            if (acc1 & port1_wb_we_i & ~oor1 & port1_wb_sel_i[i])
                mem[idx1][8*i +: 8] <= port1_wb_dat_i[8*i +: 8];
        end
    end

    memory_2rw_wb_pipe_resp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_resp0 (
        .clk    (port0_wb_clk_i),
        .rst    (port0_wb_rst_i),
        .cyc    (port0_wb_cyc_i),
        .acc    (acc0),
        .acc_err(oor0),
        .acc_rd (~port0_wb_we_i & ~oor0),
        .rdata  (mem[idx0]),
        .ack    (port0_wb_ack_o),
        .err    (port0_wb_err_o),
        .dat    (port0_wb_dat_o)
    );

    memory_2rw_wb_pipe_resp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_resp1 (
        .clk    (port0_wb_clk_i),
        .rst    (port0_wb_rst_i),
        .cyc    (port1_wb_cyc_i),
        .acc    (acc1),
        .acc_err(oor1),
        .acc_rd (~port1_wb_we_i & ~oor1),
        .rdata  (mem[idx1]),
        .ack    (port1_wb_ack_o),
        .err    (port1_wb_err_o),
        .dat    (port1_wb_dat_o)
    );
endmodule

// File: tb/tb_memory_2rw_wb_pipe.sv
// Directed bench: one latency-1 and one latency-2 instance share the same stimulus.
module tb_memory_2rw_wb_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc0, stb0, we0, cyc1, stb1, we1;
    logic [31:0] adr0, dat0, adr1, dat1;
    logic [3:0]  sel0, sel1;

    logic        l1_stall0, l1_ack0, l1_err0, l1_stall1, l1_ack1, l1_err1;
    logic        l2_stall0, l2_ack0, l2_err0, l2_stall1, l2_ack1, l2_err1;
    logic [31:0] l1_dat0, l1_dat1, l2_dat0, l2_dat1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_2rw_wb_pipe #(.READ_LATENCY(1)) dut_l1 (
        .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
        .port0_wb_cyc_i(cyc0), .port0_wb_stb_i(stb0), .port0_wb_we_i(we0),
        .port0_wb_adr_i(adr0), .port0_wb_dat_i(dat0), .port0_wb_sel_i(sel0),
        .port0_wb_stall_o(l1_stall0), .port0_wb_ack_o(l1_ack0),
        .port0_wb_err_o(l1_err0), .port0_wb_dat_o(l1_dat0),
        .port1_wb_cyc_i(cyc1), .port1_wb_stb_i(stb1), .port1_wb_we_i(we1),
        .port1_wb_adr_i(adr1), .port1_wb_dat_i(dat1), .port1_wb_sel_i(sel1),
        .port1_wb_stall_o(l1_stall1), .port1_wb_ack_o(l1_ack1),
        .port1_wb_err_o(l1_err1), .port1_wb_dat_o(l1_dat1)
    );

    memory_2rw_wb_pipe #(.READ_LATENCY(2)) dut_l2 (
        .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
        .port0_wb_cyc_i(cyc0), .port0_wb_stb_i(stb0), .port0_wb_we_i(we0),
        .port0_wb_adr_i(adr0), .port0_wb_dat_i(dat0), .port0_wb_sel_i(sel0),
        .port0_wb_stall_o(l2_stall0), .port0_wb_ack_o(l2_ack0),
        .port0_wb_err_o(l2_err0), .port0_wb_dat_o(l2_dat0),
        .port1_wb_cyc_i(cyc1), .port1_wb_stb_i(stb1), .port1_wb_we_i(we1),
        .port1_wb_adr_i(adr1), .port1_wb_dat_i(dat1), .port1_wb_sel_i(sel1),
        .port1_wb_stall_o(l2_stall1), .port1_wb_ack_o(l2_ack1),
        .port1_wb_err_o(l2_err1), .port1_wb_dat_o(l2_dat1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl);
        stb0 = s; we0 = w; adr0 = a; dat0 = d; sel0 = sl;
    endtask

    task automatic p1(input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl);
        stb1 = s; we1 = w; adr1 = a; dat1 = d; sel1 = sl;
    endtask

    initial begin
        rst = 1'b1; cyc0 = 1'b0; cyc1 = 1'b0;
        p0(0, 0, 0, 0, 0); p1(0, 0, 0, 0, 0);
        #2;
        chk("rst_l1_ack0", l1_ack0, 0);
        chk("rst_l1_err0", l1_err0, 0);
        chk("rst_l1_dat0", l1_dat0, 0);
        chk("rst_l2_ack1", l2_ack1, 0);
        chk("rst_l2_dat1", l2_dat1, 0);
        // colliding requests while in reset must not stall port 1
        cyc0 = 1; cyc1 = 1;
        p0(1, 1, 32'h40, 32'h1, 4'hF); p1(1, 0, 32'h40, 0, 4'hF);
        #1;
        chk("rst_l1_stall1", l1_stall1, 0);
        chk("rst_l2_stall1", l2_stall1, 0);
        p0(0, 0, 0, 0, 0); p1(0, 0, 0, 0, 0); cyc0 = 0; cyc1 = 0;
        tick();
        rst = 1'b0; cyc0 = 1; cyc1 = 1;

        // prefill words 0..3 through port 1
        p1(1, 1, 32'h0, 32'hA0A0A0A0, 4'hF); tick();
        chk("fill_l1_ack1", l1_ack1, 1);
        p1(1, 1, 32'h4, 32'hA1A1A1A1, 4'hF); tick();
        p1(1, 1, 32'h8, 32'hA2A2A2A2, 4'hF); tick();
        p1(1, 1, 32'hC, 32'hA3A3A3A3, 4'hF); tick();
        p1(0, 0, 0, 0, 0); tick(); tick();

        // single write then read
        p0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); tick();
        chk("wr_l1_ack0", l1_ack0, 1);
        chk("wr_l1_err0", l1_err0, 0);
        chk("wr_l2_ack0_early", l2_ack0, 0);
        p0(1, 0, 32'h10, 0, 4'hF); tick();
        chk("rd_l1_ack0", l1_ack0, 1);
        chk("rd_l1_dat0", l1_dat0, 32'hDEADBEEF);
        chk("wr_l2_ack0", l2_ack0, 1);
        p0(0, 0, 0, 0, 0); tick();
        chk("rd_l2_ack0", l2_ack0, 1);
        chk("rd_l2_dat0", l2_dat0, 32'hDEADBEEF);
        chk("rd_l1_ack0_done", l1_ack0, 0);

        // byte lanes
        p0(1, 1, 32'h20, 32'h11223344, 4'hF); tick();
        p0(1, 1, 32'h20, 32'hAABBCCDD, 4'h5); tick();
        p0(1, 0, 32'h20, 0, 4'hF); tick();
        chk("lane_l1_ack0", l1_ack0, 1);
        chk("lane_l1_dat0", l1_dat0, 32'h11BB33DD);
        p0(0, 0, 0, 0, 0); tick();
        chk("lane_l2_dat0", l2_dat0, 32'h11BB33DD);

        // write/read collision on word 0x40
        p0(1, 1, 32'h40, 32'h55, 4'hF); p1(1, 0, 32'h40, 0, 4'hF);
        #1;
        chk("col_l1_stall1", l1_stall1, 1);
        chk("col_l2_stall1", l2_stall1, 1);
        chk("col_l1_stall0", l1_stall0, 0);
        tick();
        chk("col_l1_ack0", l1_ack0, 1);
        chk("col_l1_ack1_held", l1_ack1, 0);
        p0(0, 0, 0, 0, 0);
        #1;
        chk("col_l1_stall1_clear", l1_stall1, 0);
        tick();
        chk("col_l1_ack1", l1_ack1, 1);
        chk("col_l1_dat1", l1_dat1, 32'h55);
        p1(0, 0, 0, 0, 0); tick();
        chk("col_l2_ack1", l2_ack1, 1);
        chk("col_l2_dat1", l2_dat1, 32'h55);

        // two reads of the same word never stall
        p0(1, 0, 32'h40, 0, 4'hF); p1(1, 0, 32'h40, 0, 4'hF);
        #1;
        chk("rr_l1_stall1", l1_stall1, 0);
        tick();
        chk("rr_l1_ack0", l1_ack0, 1);
        chk("rr_l1_dat0", l1_dat0, 32'h55);
        chk("rr_l1_ack1", l1_ack1, 1);
        chk("rr_l1_dat1", l1_dat1, 32'h55);
        p0(0, 0, 0, 0, 0); p1(0, 0, 0, 0, 0); tick();

        // out of range
        p0(1, 0, 32'h800, 0, 4'hF); tick();
        chk("oor_l1_err0", l1_err0, 1);
        chk("oor_l1_ack0", l1_ack0, 0);
        chk("oor_l1_dat0", l1_dat0, 32'h55);
        p0(1, 1, 32'h800, 32'hFFFFFFFF, 4'hF); tick();
        chk("oorw_l1_err0", l1_err0, 1);
        chk("oor_l2_err0", l2_err0, 1);
        chk("oor_l2_ack0", l2_ack0, 0);
        chk("oor_l2_dat0", l2_dat0, 32'h55);
        p0(1, 0, 32'h0, 0, 4'hF); tick();
        chk("w0_l1_ack0", l1_ack0, 1);
        chk("w0_l1_dat0", l1_dat0, 32'hA0A0A0A0);
        p0(0, 0, 0, 0, 0); tick();
        chk("w0_l2_dat0", l2_dat0, 32'hA0A0A0A0);

        // back-to-back reads on port 1
        p1(1, 0, 32'h0, 0, 4'hF); tick();
        chk("pipe_l2_ack1_e1", l2_ack1, 0);
        chk("pipe_l1_dat1_e1", l1_dat1, 32'hA0A0A0A0);
        p1(1, 0, 32'h4, 0, 4'hF); tick();
        chk("pipe_l2_ack1_0", l2_ack1, 1);
        chk("pipe_l2_dat1_0", l2_dat1, 32'hA0A0A0A0);
        p1(1, 0, 32'h8, 0, 4'hF); tick();
        chk("pipe_l2_ack1_1", l2_ack1, 1);
        chk("pipe_l2_dat1_1", l2_dat1, 32'hA1A1A1A1);
        p1(1, 0, 32'hC, 0, 4'hF); tick();
        chk("pipe_l2_ack1_2", l2_ack1, 1);
        chk("pipe_l2_dat1_2", l2_dat1, 32'hA2A2A2A2);
        p1(0, 0, 0, 0, 0); tick();
        chk("pipe_l2_ack1_3", l2_ack1, 1);
        chk("pipe_l2_dat1_3", l2_dat1, 32'hA3A3A3A3);
        tick();
        chk("pipe_l2_ack1_end", l2_ack1, 0);

        // abort after a read accept
        p1(1, 0, 32'h4, 0, 4'hF); tick();
        cyc1 = 0; p1(0, 0, 0, 0, 0); tick();
        chk("abort_l2_ack1", l2_ack1, 0);
        chk("abort_l2_dat1", l2_dat1, 32'hA3A3A3A3);
        cyc1 = 1; tick();
        chk("abort_l2_ack1_late", l2_ack1, 0);

        // async reset mid-burst; write accepted just before is kept
        p0(1, 1, 32'h30, 32'hCAFEF00D, 4'hF); p1(1, 0, 32'h8, 0, 4'hF); tick();
        chk("burst_l1_ack1", l1_ack1, 1);
        p0(0, 0, 0, 0, 0); p1(1, 0, 32'hC, 0, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("arst_l1_ack1", l1_ack1, 0);
        chk("arst_l1_ack0", l1_ack0, 0);
        chk("arst_l1_dat1", l1_dat1, 0);
        chk("arst_l2_dat1", l2_dat1, 0);
        cyc0 = 0; cyc1 = 0; p1(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0; cyc0 = 1; cyc1 = 1;
        p1(1, 0, 32'h30, 0, 4'hF); tick();
        chk("post_l1_ack1", l1_ack1, 1);
        chk("post_l1_dat1", l1_dat1, 32'hCAFEF00D);
        chk("post_l2_ack1_early", l2_ack1, 0);
        p1(0, 0, 0, 0, 0); tick();
        chk("post_l2_ack1", l2_ack1, 1);
        chk("post_l2_dat1", l2_dat1, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
